ball_collision_detect: RTL and testbench
========================================

BALL_COLLISION_DETECT -- requirements
Module: ball_collision_detect

Interface
REQ-001 Parameter XW, default 10, width of unsigned x/y ball-centre coordinates in pixels.
REQ-002 Parameter BALL_R, default 8, ball radius in pixels; contact threshold is (2*BALL_R)^2.
REQ-003 Parameter AXIS_TOL, default 3, maximum |offset| in pixels still treated as on-axis.
REQ-004 Parameter COOLDOWN, default 16, separated frames (>=1) required before a pair re-arms.
REQ-005 Signal clk, input, 1, rising-edge clock.
REQ-006 Signal rst, input, 1; reset rst, asynchronous, active-high; clock clk.
REQ-007 Signal frame_tick, input, 1, single-cycle strobe: positions valid this cycle; back-to-back ticks every cycle SHALL be supported.
REQ-008 Signals b1_x, b1_y, b2_x, b2_y, b3_x, b3_y, input, XW each, ball centres; screen y increases downward.
REQ-009 Signals dir12, dir13, dir23, output, 8 each, registered one-hot contact-direction pulses; bit0 LTRB, 1 RTLB, 2 LBRT, 3 RBLT, 4 LCRC, 5 RCLC, 6 CTCB, 7 CBCT.
REQ-010 Signal hit, output, 3, registered pulse, bit0 pair12, bit1 pair13, bit2 pair23; each bit = OR of that pair's dir bits.
REQ-011 Signal in_contact, output, 3, registered level, same bit order; updated once per processed frame, held otherwise.

Function
REQ-012 For pair ij: dx = xj - xi, dy = yj - yi, signed XW+1 bits; dist2 = dx*dx + dy*dy, unsigned 2*XW+3 bits, no truncation.
REQ-013 Contact SHALL mean dist2 <= (2*BALL_R)^2, inclusive.
REQ-014 Classification (T = AXIS_TOL): dx>T,dy>T LTRB; dx<-T,dy>T RTLB; dx>T,dy<-T LBRT; dx<-T,dy<-T RBLT; |dy|<=T,dx>0 LCRC; |dy|<=T,dx<0 RCLC; |dx|<=T,dy>0 CTCB; |dx|<=T,dy<0 CBCT (CT/CB diagonal rules win over axis rules is not possible; axis rules SHALL be checked first: LCRC/RCLC, then CTCB/CBCT, then diagonals).
REQ-015 dx=0 and dy=0 SHALL yield no direction: in_contact bit set, no pulse, pair FSM unchanged.
REQ-016 Pipeline: edge N samples frame_tick and captures dx/dy of all pairs (stage 1, s1_valid); edge N+1 registers dist2-compare and class (stage 2, s2_valid); edge N+2 updates pair FSMs, dir*, hit, in_contact.
REQ-017 dir*/hit SHALL be high for exactly one cycle (after edge N+2) and 0 in every other cycle.
REQ-018 Each pair SHALL have an independent FSM, states ARMED and COOL, with counter cnt of width clog2(COOLDOWN+1).
REQ-019 ARMED, s2_valid, contact, class valid: pulse dir/hit, cnt <= COOLDOWN, go COOL.
REQ-020 COOL, s2_valid, contact: no pulse, cnt <= COOLDOWN (reload).
REQ-021 COOL, s2_valid, no contact: cnt <= cnt-1; when cnt transitions to 0 go ARMED on that edge.
REQ-022 Without s2_valid, FSMs, cnt and in_contact SHALL hold.
REQ-023 Pairs firing in the same frame SHALL all pulse in the same cycle; no inter-pair priority.

Reset
REQ-024 rst SHALL clear s1_valid, s2_valid, all pipeline data, cnt=0, every FSM to ARMED, dir12=dir13=dir23=0, hit=0, in_contact=0, immediately and asynchronously.
REQ-025 Frames in flight when rst asserts SHALL be discarded; first frame_tick after rst release behaves as from power-up.

Verification
REQ-026 b1=(100,100), b2=(112,100), b3=(300,300), one tick -> dir12=8'h10 (LCRC), hit=3'b001 for one cycle two edges after tick, in_contact=3'b001.
REQ-027 b1=(100,100), b2=(110,110) (dist2=200) -> dir12=8'h01 (LTRB); b2=(116,100) -> contact (256) LCRC; b2=(117,100) -> no pulse, in_contact=0.
REQ-028 Simultaneous: b1=(100,100), b2=(100,114), b3=(100,86) -> dir12=8'h40 (CTCB), dir13=8'h80 (CBCT), dir23=0, hit=3'b011 same cycle.
REQ-029 Cooldown: contact held 5 ticks -> one pulse only; then 16 separated ticks then contact -> second pulse; with only 15 separated ticks -> no pulse.
REQ-030 Tick every cycle for 8 cycles with alternating contact/no-contact positions (COOLDOWN=1) -> pulses track frames with fixed 2-edge latency, none lost.
REQ-031 rst asserted one cycle after a contact tick -> no pulse ever emitted, all outputs 0; next contact tick after release -> normal pulse.

Source files
------------

// File: rtl/ball_collision_detect.sv
// Three-ball contact detector: per-frame pairwise distance test with one-hot
// contact direction pulses and a per-pair re-arm cooldown.
module ball_collision_detect #(
  parameter int XW       = 10,
  parameter int BALL_R   = 8,
  parameter int AXIS_TOL = 3,
  parameter int COOLDOWN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic [XW-1:0] b1_x,
  input  logic [XW-1:0] b1_y,
  input  logic [XW-1:0] b2_x,
  input  logic [XW-1:0] b2_y,
  input  logic [XW-1:0] b3_x,
  input  logic [XW-1:0] b3_y,
  output logic [7:0]    dir12,
  output logic [7:0]    dir13,
  output logic [7:0]    dir23,
  output logic [2:0]    hit,
  output logic [2:0]    in_contact
);

  localparam int DW = 2*XW + 3;
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic [DW-1:0] THR = DW'((2*BALL_R) * (2*BALL_R));
  localparam logic signed [XW:0] TOL = (XW+1)'(AXIS_TOL);

  typedef enum logic {ARMED, COOL} state_t;

  function automatic logic signed [XW:0] diff(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  function automatic logic [DW-1:0] dist2(input logic signed [XW:0] dx, input logic signed [XW:0] dy);
    logic signed [DW-1:0] dxe, dye;
    dxe = DW'(dx);
    dye = DW'(dy);
    return DW'(dxe * dxe) + DW'(dye * dye);
  endfunction

  // Axis rules take precedence over diagonals; dx=dy=0 yields no class.
  function automatic logic [7:0] classify(input logic signed [XW:0] dx, input logic signed [XW:0] dy);
    logic dx_ax, dy_ax;
    dx_ax = (dx <= TOL) && (dx >= -TOL);
    dy_ax = (dy <= TOL) && (dy >= -TOL);
    classify = 8'h00;
    if (dy_ax && dx > 0)               classify = 8'h10;
    else if (dy_ax && dx < 0)          classify = 8'h20;
    else if (dx_ax && dy > 0)          classify = 8'h40;
    else if (dx_ax && dy < 0)          classify = 8'h80;
    else if (dx > TOL && dy > TOL)     classify = 8'h01;
    else if (dx < -TOL && dy > TOL)    classify = 8'h02;
    else if (dx > TOL && dy < -TOL)    classify = 8'h04;
    else if (dx < -TOL && dy < -TOL)   classify = 8'h08;
  endfunction

  logic                 s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic signed [XW:0]   dx_d [3], dx_q [3], dy_d [3], dy_q [3];
  logic [2:0]           contact_d, contact_q;
  logic [7:0]           cls_d [3], cls_q [3];
  state_t               state_d [3], state_q [3];
  logic [CW-1:0]        cnt_d [3], cnt_q [3];
  logic [7:0]           dir_d [3], dir_q [3];
  logic [2:0]           hit_d, hit_q, in_contact_d, in_contact_q;

  always_comb begin
    s1_valid_d = frame_tick;
    for (int p = 0; p < 3; p++) begin
      dx_d[p] = dx_q[p];
      dy_d[p] = dy_q[p];
    end
    if (frame_tick) begin
      dx_d[0] = diff(b2_x, b1_x);  dy_d[0] = diff(b2_y, b1_y);
      dx_d[1] = diff(b3_x, b1_x);  dy_d[1] = diff(b3_y, b1_y);
      dx_d[2] = diff(b3_x, b2_x);  dy_d[2] = diff(b3_y, b2_y);
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    contact_d  = contact_q;
    for (int p = 0; p < 3; p++) cls_d[p] = cls_q[p];
    if (s1_valid_q) begin
      for (int p = 0; p < 3; p++) begin
        contact_d[p] = dist2(dx_q[p], dy_q[p]) <= THR;
        cls_d[p]     = classify(dx_q[p], dy_q[p]);
      end
    end
  end

  always_comb begin
    in_contact_d = in_contact_q;
    hit_d        = '0;
    for (int p = 0; p < 3; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      dir_d[p]   = '0;
      if (s2_valid_q) begin
        if (contact_q[p]) begin
          if (cls_q[p] != 8'h00) begin
            if (state_q[p] == ARMED) dir_d[p] = cls_q[p];
            cnt_d[p]   = CW'(COOLDOWN);
            state_d[p] = COOL;
          end
        end else if (state_q[p] == COOL) begin
          if (cnt_q[p] != '0) cnt_d[p] = cnt_q[p] - 1'b1;
          if (cnt_q[p] <= CW'(1)) state_d[p] = ARMED;
        end
      end
      hit_d[p] = |dir_d[p];
    end
    if (s2_valid_q) in_contact_d = contact_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      contact_q    <= '0;
      hit_q        <= '0;
      in_contact_q <= '0;
      for (int p = 0; p < 3; p++) begin
        dx_q[p]    <= '0;
        dy_q[p]    <= '0;
        cls_q[p]   <= '0;
        state_q[p] <= ARMED;
        cnt_q[p]   <= '0;
        dir_q[p]   <= '0;
      end
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      contact_q    <= contact_d;
      hit_q        <= hit_d;
      in_contact_q <= in_contact_d;
      for (int p = 0; p < 3; p++) begin
        dx_q[p]    <= dx_d[p];
        dy_q[p]    <= dy_d[p];
        cls_q[p]   <= cls_d[p];
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        dir_q[p]   <= dir_d[p];
      end
    end
  end

  assign dir12      = dir_q[0];
  assign dir13      = dir_q[1];
  assign dir23      = dir_q[2];
  assign hit        = hit_q;
  assign in_contact = in_contact_q;

endmodule

// File: tb/tb_ball_collision_detect.sv
// Directed bench for ball_collision_detect: default instance plus a
// COOLDOWN=1 instance for back-to-back frame tracking.
module tb_ball_collision_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       tick_c1 = 1'b0;
  logic [9:0] b1_x = '0, b1_y = '0, b2_x = '0, b2_y = '0, b3_x = '0, b3_y = '0;
  logic [7:0] dir12, dir13, dir23, dir12_c1, dir13_c1, dir23_c1;
  logic [2:0] hit, in_contact, hit_c1, in_contact_c1;

  int n_chk = 0;
  int n_err = 0;
  int np;

  always #5 clk = ~clk;

  ball_collision_detect dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .b1_x(b1_x), .b1_y(b1_y), .b2_x(b2_x), .b2_y(b2_y), .b3_x(b3_x), .b3_y(b3_y),
    .dir12(dir12), .dir13(dir13), .dir23(dir23), .hit(hit), .in_contact(in_contact)
  );

  ball_collision_detect #(.COOLDOWN(1)) dut_c1 (
    .clk(clk), .rst(rst), .frame_tick(tick_c1),
    .b1_x(b1_x), .b1_y(b1_y), .b2_x(b2_x), .b2_y(b2_y), .b3_x(b3_x), .b3_y(b3_y),
    .dir12(dir12_c1), .dir13(dir13_c1), .dir23(dir23_c1), .hit(hit_c1), .in_contact(in_contact_c1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_balls(input int x1, y1, x2, y2, x3, y3);
    b1_x = 10'(x1); b1_y = 10'(y1);
    b2_x = 10'(x2); b2_y = 10'(y2);
    b3_x = 10'(x3); b3_y = 10'(y3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One tick, then advance to just after the output edge (N+2).
  task automatic frame(input int x1, y1, x2, y2, x3, y3);
    set_balls(x1, y1, x2, y2, x3, y3);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dir12", dir12, 8'h00);
    chk("rst_dir13", dir13, 8'h00);
    chk("rst_dir23", dir23, 8'h00);
    chk("rst_hit", hit, 3'b000);
    chk("rst_inc", in_contact, 3'b000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic LCRC with latency check.
    set_balls(100, 100, 112, 100, 300, 300);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
    chk("lat_n1_hit", hit, 3'b000);
    @(posedge clk); #1;
    chk("basic_dir12", dir12, 8'h10);
    chk("basic_dir13", dir13, 8'h00);
    chk("basic_hit", hit, 3'b001);
    chk("basic_inc", in_contact, 3'b001);
    @(posedge clk); #1;
    chk("basic_pulse_end", hit, 3'b000);
    chk("basic_inc_hold", in_contact, 3'b001);

    do_reset();
    frame(100, 100, 110, 110, 300, 300);
    chk("ltrb_dir12", dir12, 8'h01);
    do_reset();
    frame(100, 100, 116, 100, 300, 300);
    chk("thr256_dir12", dir12, 8'h10);
    do_reset();
    frame(100, 100, 117, 100, 300, 300);
    chk("thr289_hit", hit, 3'b000);
    chk("thr289_inc", in_contact, 3'b000);

    do_reset();
    frame(100, 100, 100, 114, 100, 86);
    chk("sim_dir12", dir12, 8'h40);
    chk("sim_dir13", dir13, 8'h80);
    chk("sim_dir23", dir23, 8'h00);
    chk("sim_hit", hit, 3'b011);

    do_reset();
    frame(100, 100, 90, 110, 110, 90);
    chk("rtlb_dir12", dir12, 8'h02);
    chk("lbrt_dir13", dir13, 8'h04);
    chk("diag_hit", hit, 3'b011);
    do_reset();
    frame(100, 100, 88, 101, 90, 90);
    chk("rclc_dir12", dir12, 8'h20);
    chk("rblt_dir13", dir13, 8'h08);
    chk("cbct_dir23", dir23, 8'h80);
    chk("all_hit", hit, 3'b111);
    do_reset();
    frame(100, 100, 110, 103, 300, 300);
    chk("tol3_dir12", dir12, 8'h10);
    do_reset();
    frame(100, 100, 110, 104, 300, 300);
    chk("tol4_dir12", dir12, 8'h01);

    // Coincident centres: contact without a direction, FSM stays armed.
    do_reset();
    frame(200, 200, 200, 200, 500, 500);
    chk("zero_hit", hit, 3'b000);
    chk("zero_inc", in_contact, 3'b001);
    frame(200, 200, 210, 200, 500, 500);
    chk("zero_then_dir12", dir12, 8'h10);

    // Cooldown with COOLDOWN=16.
    do_reset();
    np = 0;
    for (int i = 0; i < 5; i++) begin
      frame(100, 100, 112, 100, 500, 500);
      np += int'(hit[0]);
    end
    chk("cool_hold_pulses", np, 1);
    for (int i = 0; i < 16; i++) begin
      frame(100, 100, 200, 100, 500, 500);
      np += int'(hit[0]);
    end
    chk("cool_sep_pulses", np, 1);
    chk("cool_sep_inc", in_contact, 3'b000);
    frame(100, 100, 112, 100, 500, 500);
    chk("cool_rearm16", hit, 3'b001);
    for (int i = 0; i < 15; i++) frame(100, 100, 200, 100, 500, 500);
    frame(100, 100, 112, 100, 500, 500);
    chk("cool_sep15", hit, 3'b000);
    chk("cool_sep15_inc", in_contact, 3'b001);

    // Back-to-back ticks on the COOLDOWN=1 instance.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        tick_c1 = 1'b1;
        set_balls(100, 100, (k % 2 == 0) ? 112 : 200, 100, 500, 500);
      end else begin
        tick_c1 = 1'b0;
      end
      @(posedge clk); #1;
      if (k >= 2) begin
        chk($sformatf("b2b_hit_f%0d", k - 2), hit_c1, ((k - 2) % 2 == 0) ? 3'b001 : 3'b000);
        chk($sformatf("b2b_dir_f%0d", k - 2), dir12_c1, ((k - 2) % 2 == 0) ? 8'h10 : 8'h00);
      end
    end
    tick_c1 = 1'b0;

    // Reset one cycle after a contact tick discards the frame.
    do_reset();
    set_balls(100, 100, 112, 100, 500, 500);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    rst = 1'b1;
    #1;
    chk("inflight_rst_hit", hit, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("inflight_rst_inc", in_contact, 3'b000);
    rst = 1'b0;
    np = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      np += int'(hit != 3'b000) + int'(dir12 != 8'h00);
    end
    chk("inflight_no_pulse", np, 0);
    chk("inflight_inc_after", in_contact, 3'b000);
    frame(100, 100, 112, 100, 500, 500);
    chk("after_rst_dir12", dir12, 8'h10);
    chk("after_rst_hit", hit, 3'b001);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
